// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction ROM
// address, and loads the IF/ID pipeline register. It handles branch and jump
// redirects, back-end stalls, decode back-pressure and a sticky halt.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [25:0]      jmp_index,
    output logic [31:0]      rom_pc,
    input  logic [31:0]      rom_inst,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t           state_r;
    logic [31:0]      pc_r;
    logic [31:0]      id_inst_r;
    logic [31:0]      id_pc4_r;
    logic             id_valid_r;
    logic [CNT_W-1:0] fetch_cnt_r;

    logic [31:0]      pc_plus4_s;
    logic [31:0]      br_addr_s;
    logic             redirect_s;
    logic [31:0]      target_s;
    logic             fetch_s;
    logic             cnt_full_s;

    // Next-PC arithmetic, redirect selection and the fetch condition.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        br_addr_s  = br_target & 32'hFFFF_FFFC;
        cnt_full_s = &fetch_cnt_r;
        redirect_s = 1'b0;
        target_s   = pc_r;
        fetch_s    = 1'b0;
        // Redirects are honoured in every state except HALT; jump wins over branch.
        if (state_r != ST_HALT) begin
            if (jmp) begin
                redirect_s = 1'b1;
                target_s   = {id_pc4_r[31:28], jmp_index, 2'b00};
            end else if (br_taken) begin
                redirect_s = 1'b1;
                target_s   = br_addr_s;
            end else begin
                redirect_s = 1'b0;
                target_s   = pc_r;
            end
        end else begin
            redirect_s = 1'b0;
            target_s   = pc_r;
        end
        // A redirect cancels the fetch in the same cycle.
        if ((state_r == ST_RUN) && en && !halt_req && !stall &&
            (!id_valid_r || id_ready) && !redirect_s) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
    end

    // FSM, PC and IF/ID register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            id_inst_r   <= 32'h0000_0000;
            id_pc4_r    <= 32'h0000_0000;
            id_valid_r  <= 1'b0;
            fetch_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) state_r <= ST_RUN;
                    else    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (halt_req) state_r <= ST_HALT;
                    else if (!en) state_r <= ST_IDLE;
                    else          state_r <= ST_RUN;
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_IDLE;
            endcase

            if (redirect_s) begin
                pc_r       <= target_s;
                id_valid_r <= 1'b0;
            end else if (fetch_s) begin
                pc_r        <= pc_plus4_s;
                id_inst_r   <= rom_inst;
                id_pc4_r    <= pc_plus4_s;
                id_valid_r  <= 1'b1;
                if (!cnt_full_s) fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
                else             fetch_cnt_r <= fetch_cnt_r;
            end else if (id_valid_r && id_ready) begin
                // Decode consumed the word and nothing replaces it.
                id_valid_r <= 1'b0;
            end else begin
                id_valid_r <= id_valid_r;
            end
        end
    end

    assign rom_pc    = pc_r;
    assign id_inst   = id_inst_r;
    assign id_pc4    = id_pc4_r;
    assign id_valid  = id_valid_r;
    assign state     = state_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the fetch counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst_n  input  1: asynchronous active-low reset.
REQ-006 Port en  input  1: run enable.
REQ-007 Port halt_req  input  1: halt request, sticky once taken.
REQ-008 Port stall  input  1: back-end stall.
REQ-009 Port br_taken  input  1: branch redirect.
REQ-010 Port br_target  input  32: absolute branch byte address.
REQ-011 Port jmp  input  1: jump redirect.
REQ-012 Port jmp_index  input  26: J-type instruction index.
REQ-013 Port rom_pc  output  32: address to instruction ROM.
REQ-014 Port rom_inst  input  32: combinational ROM data for rom_pc.
REQ-015 Port id_inst  output  32: IF/ID instruction.
REQ-016 Port id_pc4  output  32: IF/ID PC+4 of id_inst.
REQ-017 Port id_valid  output  1: id_inst holds a live instruction.
REQ-018 Port id_ready  input  1: decode accepts id_inst this cycle.
REQ-019 Port state  output  2: FSM state (00 IDLE, 01 RUN, 10 HALT).
REQ-020 Port fetch_cnt  output  CNT_W: count of instructions loaded into IF/ID.

Function
REQ-021 rom_pc SHALL equal the PC register combinationally.
REQ-022 FSM transitions SHALL be: IDLE->RUN when en=1; RUN->IDLE when en=0 and halt_req=0; RUN->HALT when halt_req=1 (priority over en); HALT is terminal until reset.
REQ-023 A "fetch" SHALL occur in a cycle iff state=RUN, en=1, halt_req=0, stall=0, and (id_valid=0 or id_ready=1).
REQ-024 On a fetch with no redirect: id_inst<=rom_inst, id_pc4<=PC+4, id_valid<=1, PC<=PC+4, fetch_cnt increments.
REQ-025 Redirect priority SHALL be jmp > br_taken > sequential.
REQ-026 Jump target SHALL be {PC_plus4[31:28], jmp_index, 2'b00}, where PC_plus4 is id_pc4.
REQ-027 Branch target SHALL be {br_target[31:2], 2'b00}; low bits are ignored.
REQ-028 A redirect (jmp or br_taken) SHALL be applied in any state except HALT, regardless of stall, en or id_ready: PC<=target, id_valid<=0, no fetch, fetch_cnt unchanged.
REQ-029 Without a fetch or redirect, PC, id_inst and id_pc4 SHALL hold.
REQ-030 If id_valid=1 and id_ready=1 with no fetch, id_valid SHALL go to 0 next cycle.
REQ-031 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 fetch_cnt SHALL saturate at all-ones.
REQ-033 In HALT: PC frozen; redirects ignored; id_valid clears after its last acceptance and then stays 0.
REQ-034 In IDLE: PC held; id_valid follows REQ-030 (drains); no fetch.

Reset
REQ-035 While rst_n=0, asynchronously: PC=RESET_PC, id_inst=0, id_pc4=0, id_valid=0, state=IDLE, fetch_cnt=0.
REQ-036 Reset asserted mid-operation SHALL discard any in-flight IF/ID contents and pending redirect.
REQ-037 The first fetch after reset SHALL occur no earlier than the second rising edge after rst_n deasserts (IDLE->RUN, then fetch).

Verification
REQ-038 Reset release, en=1, id_ready=1, ROM word k = k: id_inst sequence 0,1,2,3; id_pc4 4,8,12,16; fetch_cnt=4 after 4 fetches.
REQ-039 Hold id_ready=0 for 3 cycles with id_valid=1: id_inst, PC and fetch_cnt are unchanged; the next word appears the cycle after id_ready=1.
REQ-040 Assert br_taken with br_target=32'h0000_0023 while stall=1: next PC=32'h20, id_valid=0, then id_inst=ROM[8].
REQ-041 Assert jmp and br_taken together, jmp_index=26'h8, id_pc4=32'h3000_0010: PC=32'h3000_0020.
REQ-042 Set RESET_PC=32'hFFFF_FFFC and fetch once: id_pc4=0, PC=0; with CNT_W=2 and 5 fetches, fetch_cnt=3.
REQ-043 halt_req pulse in RUN: state=HALT; a later jmp has no effect on PC; rst_n low restores state=IDLE and PC=RESET_PC.
